// File: rtl/div_pkg.sv
// Shared types and constants for the restoring-divider host sequencer.
package div_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    DIV_SEQ_IDLE,
    DIV_SEQ_ARM,
    DIV_SEQ_PULSE,
    DIV_SEQ_RUN,
    DIV_SEQ_RESP
  } div_seq_state_e;

  typedef logic [1:0] div_err_t;

  localparam div_err_t DIV_ERR_OK      = 2'd0;
  localparam div_err_t DIV_ERR_TIMEOUT = 2'd1;
  localparam div_err_t DIV_ERR_DIVZERO = 2'd2;

endpackage

// File: rtl/div_seq_timer.sv
// Loadable down-counter; shared by the start-pulse width and the run timeout.
module div_seq_timer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CW = $clog2(TIMEOUT_CYC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_zero
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/div_req_seq.sv
// Host-side request/response sequencer for the 8-bit restoring divider.
// Optional DIV_ZERO_CHK_EN: answer divisor==0 locally without starting the divider.
module div_req_seq
  import div_pkg::*;
#(
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_dividend,
  input  logic [DIV_W-1:0] req_divisor,
  output logic             div_start,
  input  logic             div_idle,
  input  logic             ld_a,
  input  logic             ld_q,
  input  logic             ld_m,
  output logic [DIV_W-1:0] div_inbus,
  input  logic             out_q,
  input  logic             out_r,
  input  logic [DIV_W-1:0] div_outbus,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DIV_W-1:0] rsp_quotient,
  output logic [DIV_W-1:0] rsp_remainder,
  output logic [1:0]       rsp_err,
  output logic             rsp_ovf
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  div_seq_state_e r_state;
  div_seq_state_e w_next;

  logic [15:0]      r_dividend;
  logic [DIV_W-1:0] r_divisor;
  logic [DIV_W-1:0] r_quot;
  logic             r_ovf;

  logic          w_tmr_load;
  logic          w_tmr_en;
  logic          w_tmr_zero;
  logic [CW-1:0] w_tmr_val;
  logic          w_divzero;

`ifdef DIV_ZERO_CHK_EN
  assign w_divzero = (req_divisor == '0);
`else
  assign w_divzero = 1'b0;
`endif

  div_seq_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CW         (CW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .i_en      (w_tmr_en),
    .o_zero    (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= DIV_SEQ_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_en   = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      DIV_SEQ_IDLE: begin
        if (req_valid) begin
          w_next = w_divzero ? DIV_SEQ_RESP : DIV_SEQ_ARM;
        end
      end
      DIV_SEQ_ARM: begin
        if (div_idle) begin
          w_next     = DIV_SEQ_PULSE;
          w_tmr_load = 1'b1;
          w_tmr_val  = CW'(START_CYCLES - 1);
        end
      end
      DIV_SEQ_PULSE: begin
        if (w_tmr_zero) begin
          w_next     = DIV_SEQ_RUN;
          w_tmr_load = 1'b1;
          w_tmr_val  = CW'(TIMEOUT_CYC - 1);
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      DIV_SEQ_RUN: begin
        if (out_r || w_tmr_zero) w_next = DIV_SEQ_RESP;
        else                     w_tmr_en = 1'b1;
      end
      DIV_SEQ_RESP: begin
        if (rsp_ready) w_next = DIV_SEQ_IDLE;
      end
      default: w_next = DIV_SEQ_IDLE;
    endcase
  end

  assign req_ready = !rst && (r_state == DIV_SEQ_IDLE);
  assign div_start = !rst && (r_state == DIV_SEQ_PULSE);
  assign rsp_valid = !rst && (r_state == DIV_SEQ_RESP);

  // Operand mux is combinational so the divider samples it in the strobe cycle.
  always_comb begin
    div_inbus = '0;
    if (!rst && (r_state == DIV_SEQ_RUN)) begin
      if (ld_a)      div_inbus = r_dividend[15:8];
      else if (ld_q) div_inbus = r_dividend[7:0];
      else if (ld_m) div_inbus = r_divisor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_quot        <= '0;
      r_ovf         <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_err       <= DIV_ERR_OK;
      rsp_ovf       <= 1'b0;
    end else begin
      case (r_state)
        DIV_SEQ_IDLE: begin
          if (req_valid) begin
            r_dividend <= req_dividend;
            r_divisor  <= req_divisor;
            r_ovf      <= (req_dividend[15:8] >= req_divisor);
            r_quot     <= '0;
            if (w_divzero) begin
              rsp_quotient  <= '1;
              rsp_remainder <= req_dividend[7:0];
              rsp_err       <= DIV_ERR_DIVZERO;
              rsp_ovf       <= 1'b1;
            end
          end
        end
        DIV_SEQ_RUN: begin
          if (out_q) r_quot <= div_outbus;
          if (out_r || w_tmr_zero) begin
            rsp_quotient  <= out_q ? div_outbus : r_quot;
            rsp_remainder <= out_r ? div_outbus : '0;
            rsp_err       <= out_r ? DIV_ERR_OK : DIV_ERR_TIMEOUT;
            rsp_ovf       <= r_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_req_seq.sv
// Directed bench for div_req_seq with a behavioural divider driven from tasks.
module tb_div_req_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_dividend;
  logic [7:0]  req_divisor;
  logic        div_start;
  logic        div_idle;
  logic        ld_a, ld_q, ld_m;
  logic [7:0]  div_inbus;
  logic        out_q, out_r;
  logic [7:0]  div_outbus;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_quotient;
  logic [7:0]  rsp_remainder;
  logic [1:0]  rsp_err;
  logic        rsp_ovf;

  int vecs = 0;
  int errs = 0;
  bit ds_seen = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (div_start === 1'b1) ds_seen <= 1'b1;

  div_req_seq dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .div_start    (div_start),
    .div_idle     (div_idle),
    .ld_a         (ld_a),
    .ld_q         (ld_q),
    .ld_m         (ld_m),
    .div_inbus    (div_inbus),
    .out_q        (out_q),
    .out_r        (out_r),
    .div_outbus   (div_outbus),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_quotient (rsp_quotient),
    .rsp_remainder(rsp_remainder),
    .rsp_err      (rsp_err),
    .rsp_ovf      (rsp_ovf)
  );

  task automatic send_req(input logic [15:0] dd, input logic [7:0] dv);
    @(negedge clk);
    req_valid = 1'b1; req_dividend = dd; req_divisor = dv;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits for the start pulse, plays the load strobes, then returns results.
  task automatic div_model(input bit send_r, input bit both,
                           input logic [7:0] rq_in, input logic [7:0] rr_in,
                           input bit compute,
                           output logic [7:0] ca, output logic [7:0] cq,
                           output logic [7:0] cm, output int width,
                           output int k, output bit ok);
    int n = 0;
    logic [15:0] t;
    logic [7:0] rq, rr;
    rq = rq_in; rr = rr_in;
    ok = 0; width = 0; k = 0; ca = 0; cq = 0; cm = 0;
    #1;
    while (div_start !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    if (div_start !== 1'b1) return;
    while (div_start === 1'b1 && width < 10) begin width++; @(negedge clk); #1; end
    ld_a = 1; #1 ca = div_inbus;
    @(negedge clk); k = 1; ld_a = 0; ld_q = 1; #1 cq = div_inbus;
    @(negedge clk); k = 2; ld_q = 0; ld_m = 1; #1 cm = div_inbus;
    @(negedge clk); k = 3; ld_m = 0;
    if (compute && cm != 0) begin
      t = {ca, cq};
      rq = 8'(t / {8'h00, cm});
      rr = 8'(t % {8'h00, cm});
    end
    repeat (4) begin @(negedge clk); k++; end
    if (both) begin
      out_q = 1; out_r = 1; div_outbus = rr; ok = 1; return;
    end
    out_q = 1; div_outbus = rq;
    @(negedge clk); k++; out_q = 0;
    if (send_r) begin out_r = 1; div_outbus = rr; end
    else div_outbus = 0;
    ok = 1;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 0; req_dividend = 0; req_divisor = 0;
    div_idle = 1; ld_a = 0; ld_q = 0; ld_m = 0;
    out_q = 0; out_r = 0; div_outbus = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rst_ready_in_reset got %b want 0", req_ready); end
    rst = 0; #1;
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_ready_after got %b want 1", req_ready); end
    vecs++;
    if ({div_start, div_inbus, rsp_valid, rsp_quotient, rsp_remainder, rsp_err, rsp_ovf} !== 29'd0) begin
      errs++;
      $display("FAIL rst_outputs got start=%b inbus=%h v=%b q=%h r=%h e=%0d o=%b want all 0",
               div_start, div_inbus, rsp_valid, rsp_quotient, rsp_remainder, rsp_err, rsp_ovf);
    end
  endtask

  task automatic test_basic();
    logic [7:0] a, q, m; int w, k; bit ok;
    send_req(16'd1000, 8'd7);
    div_model(1, 0, 8'h00, 8'h00, 1, a, q, m, w, k, ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL basic_start got none want pulse"); end
    vecs++; if (w != 1) begin errs++; $display("FAIL basic_pulse_width got %0d want 1", w); end
    vecs++; if (a !== 8'h03) begin errs++; $display("FAIL basic_ld_a got %h want 03", a); end
    vecs++; if (q !== 8'hE8) begin errs++; $display("FAIL basic_ld_q got %h want e8", q); end
    vecs++; if (m !== 8'h07) begin errs++; $display("FAIL basic_ld_m got %h want 07", m); end
    #1;
    vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL basic_early_valid got %b want 0", rsp_valid); end
    @(negedge clk); out_r = 0; div_outbus = 0; #1;
    vecs++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %b want 1", rsp_valid); end
    vecs++; if (rsp_quotient !== 8'd142) begin errs++; $display("FAIL basic_q got %0d want 142", rsp_quotient); end
    vecs++; if (rsp_remainder !== 8'd6) begin errs++; $display("FAIL basic_r got %0d want 6", rsp_remainder); end
    vecs++; if (rsp_err !== 2'd0 || rsp_ovf !== 1'b0) begin errs++; $display("FAIL basic_err_ovf got %0d/%b want 0/0", rsp_err, rsp_ovf); end
    vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL basic_ready_in_resp got %b want 0", req_ready); end
    finish_rsp(); #1;
    vecs++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errs++; $display("FAIL basic_back_idle got v=%b rdy=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_hold();
    logic [7:0] a, q, m; int w, k; bit ok;
    send_req(16'd500, 8'd9);
    div_model(1, 0, 8'h00, 8'h00, 1, a, q, m, w, k, ok);
    @(negedge clk); out_r = 0; div_outbus = 0;
    for (int i = 0; i < 10; i++) begin
      ld_a = 1; out_q = 1; out_r = 1; div_outbus = 8'hEE; #1;
      vecs++;
      if (rsp_valid !== 1'b1 || rsp_quotient !== 8'd55 || rsp_remainder !== 8'd5 || div_inbus !== 8'h00) begin
        errs++;
        $display("FAIL hold_cycle%0d got v=%b q=%0d r=%0d inbus=%h want 1/55/5/00",
                 i, rsp_valid, rsp_quotient, rsp_remainder, div_inbus);
      end
      @(negedge clk);
    end
    ld_a = 0; out_q = 0; out_r = 0; div_outbus = 0;
    finish_rsp(); #1;
    vecs++; if (rsp_valid !== 1'b0 || rsp_quotient !== 8'd55) begin errs++; $display("FAIL hold_release got v=%b q=%0d want 0/55", rsp_valid, rsp_quotient); end
  endtask

  task automatic test_ovf();
    logic [7:0] a, q, m; int w, k; bit ok; bit early;
    div_idle = 0; early = 0;
    send_req(16'h0A00, 8'h05);
    repeat (5) begin @(negedge clk); #1; if (div_start !== 1'b0) early = 1; end
    vecs++; if (early) begin errs++; $display("FAIL ovf_arm_wait got start=1 want 0"); end
    div_idle = 1;
    div_model(1, 0, 8'hA5, 8'h3C, 0, a, q, m, w, k, ok);
    vecs++; if ({a, q, m} !== 24'h0A0005 || ok !== 1'b1) begin errs++; $display("FAIL ovf_loads got %h%h%h ok=%b want 0a0005", a, q, m, ok); end
    @(negedge clk); out_r = 0; div_outbus = 0; #1;
    vecs++;
    if (rsp_quotient !== 8'hA5 || rsp_remainder !== 8'h3C || rsp_ovf !== 1'b1 || rsp_err !== 2'd0) begin
      errs++;
      $display("FAIL ovf_rsp got q=%h r=%h o=%b e=%0d want a5/3c/1/0", rsp_quotient, rsp_remainder, rsp_ovf, rsp_err);
    end
    finish_rsp();
  endtask

  task automatic test_same_cycle();
    logic [7:0] a, q, m; int w, k; bit ok;
    send_req(16'h0123, 8'h10);
    div_model(1, 1, 8'h00, 8'h5A, 0, a, q, m, w, k, ok);
    @(negedge clk); out_q = 0; out_r = 0; div_outbus = 0; #1;
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_quotient !== 8'h5A || rsp_remainder !== 8'h5A || rsp_ovf !== 1'b0) begin
      errs++;
      $display("FAIL same_cycle got v=%b q=%h r=%h o=%b want 1/5a/5a/0", rsp_valid, rsp_quotient, rsp_remainder, rsp_ovf);
    end
    finish_rsp();
  endtask

  task automatic test_timeout();
    logic [7:0] a, q, m; int w, k; bit ok;
    send_req(16'h0100, 8'h02);
    div_model(0, 0, 8'h77, 8'h00, 0, a, q, m, w, k, ok);
    #1;
    while (rsp_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; #1; end
    vecs++; if (k != 64) begin errs++; $display("FAIL timeout_latency got %0d want 64", k); end
    vecs++;
    if (rsp_err !== 2'd1 || rsp_quotient !== 8'h77 || rsp_remainder !== 8'h00 || rsp_ovf !== 1'b0) begin
      errs++;
      $display("FAIL timeout_rsp got e=%0d q=%h r=%h o=%b want 1/77/00/0", rsp_err, rsp_quotient, rsp_remainder, rsp_ovf);
    end
  endtask

  task automatic test_reset_run();
    int n = 0;
    finish_rsp();
    send_req(16'h2000, 8'h40);
    #1;
    while (div_start !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    while (div_start === 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
    ld_a = 1; #1;
    vecs++; if (div_inbus !== 8'h20) begin errs++; $display("FAIL rrun_inbus got %h want 20", div_inbus); end
    @(negedge clk); ld_a = 0; rst = 1; #1;
    vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rrun_ready_in_reset got %b want 0", req_ready); end
    @(negedge clk); rst = 0; #1;
    vecs++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || {rsp_quotient, rsp_remainder, rsp_err, rsp_ovf} !== 19'd0) begin
      errs++;
      $display("FAIL rrun_cleared got rdy=%b v=%b q=%h r=%h e=%0d o=%b want 1/0/0/0/0/0",
               req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err, rsp_ovf);
    end
    ld_a = 1; out_q = 1; out_r = 1; div_outbus = 8'h99; #1;
    vecs++; if (div_inbus !== 8'h00) begin errs++; $display("FAIL rrun_stray_inbus got %h want 00", div_inbus); end
    @(negedge clk); ld_a = 0; out_q = 0; out_r = 0; div_outbus = 0; #1;
    vecs++;
    if (rsp_valid !== 1'b0 || rsp_quotient !== 8'h00 || req_ready !== 1'b1) begin
      errs++;
      $display("FAIL rrun_stray_rsp got v=%b q=%h rdy=%b want 0/00/1", rsp_valid, rsp_quotient, req_ready);
    end
  endtask

`ifdef DIV_ZERO_CHK_EN
  task automatic test_divzero();
    ds_seen = 0;
    @(negedge clk);
    req_valid = 1; req_dividend = 16'h1234; req_divisor = 8'h00;
    @(negedge clk); req_valid = 0; #1;
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_err !== 2'd2 || rsp_quotient !== 8'hFF || rsp_remainder !== 8'h34 || rsp_ovf !== 1'b1) begin
      errs++;
      $display("FAIL divzero_rsp got v=%b e=%0d q=%h r=%h o=%b want 1/2/ff/34/1",
               rsp_valid, rsp_err, rsp_quotient, rsp_remainder, rsp_ovf);
    end
    finish_rsp();
    repeat (3) @(negedge clk);
    vecs++; if (ds_seen !== 1'b0) begin errs++; $display("FAIL divzero_start got 1 want 0"); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_ovf();
    test_same_cycle();
    test_timeout();
    test_reset_run();
`ifdef DIV_ZERO_CHK_EN
    test_divzero();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

endmodule
